// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter sharing one single-port SRAM among N_REQ requesters.
// Ports: clk/rst; per-requester req/we/addr/wdata/lock in, gnt/rvalid out; shared rdata out;
//        SRAM side sram_csn/sram_wen/sram_ad/sram_din out, sram_dout in.
// Latency: gnt combinational in accept cycle t, SRAM command in t+1, rvalid/rdata in t+2.
// Optional feature macro: ARB_BURST_EN (lock-based burst hold, up to MAX_BURST grants).
module sram_arbiter #(
  parameter int N_REQ     = 3,
  parameter int AW        = 19,
  parameter int DW        = 16,
  parameter int MAX_BURST = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    we,
  input  logic [N_REQ*AW-1:0] addr,
  input  logic [N_REQ*DW-1:0] wdata,
  input  logic [N_REQ-1:0]    lock,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    rvalid,
  output logic [DW-1:0]       rdata,
  output logic                sram_csn,
  output logic                sram_wen,
  output logic [AW-1:0]       sram_ad,
  output logic [DW-1:0]       sram_din,
  input  logic [DW-1:0]       sram_dout
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

`ifdef ARB_BURST_EN
  typedef enum logic [1:0] {IDLE, ISSUE, LOCKED} state_t;
`else
  typedef enum logic [1:0] {IDLE, ISSUE} state_t;
`endif

  state_t          state;
  logic [PW-1:0]   ptr;        // last granted requester
  logic            p1_vld;     // read in flight, command currently on SRAM bus
  logic [PW-1:0]   p1_id;

  logic            rr_any;
  logic [PW-1:0]   rr_id;
  logic            sel_any;
  logic [PW-1:0]   sel_id;

  // Round-robin search starting one past the last winner.
  always_comb begin
    int idx;
    rr_any = 1'b0;
    rr_id  = '0;
    idx    = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!rr_any && req[idx]) begin
        rr_any = 1'b1;
        rr_id  = PW'(idx);
      end
    end
  end

`ifdef ARB_BURST_EN
  logic [PW-1:0] holder;
  logic [CW-1:0] burst_cnt;
  logic          lock_hit;

  // Holder keeps the bus only while it still asks for it and has budget left.
  assign lock_hit = (state == LOCKED) && req[holder] && lock[holder] &&
                    (burst_cnt < CW'(MAX_BURST));
  assign sel_any  = rr_any | lock_hit;
  assign sel_id   = lock_hit ? holder : rr_id;
`else
  assign sel_any  = rr_any;
  assign sel_id   = rr_id;

  // Without burst mode the lock inputs and the FSM state have no consumer.
  logic unused_sigs;
  assign unused_sigs = ^lock ^ (state == IDLE);
`endif

  // Gated by rst so nothing appears accepted while the pipe is held in reset.
  assign gnt   = (sel_any && !rst) ? (N_REQ'(1) << sel_id) : '0;

  // sram_dout is already the SRAM output register, aligned with the rvalid strobe.
  assign rdata = (|rvalid) ? sram_dout : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= PW'(N_REQ - 1);
      sram_csn <= 1'b1;
      sram_wen <= 1'b0;
      sram_ad  <= '0;
      sram_din <= '0;
      p1_vld   <= 1'b0;
      p1_id    <= '0;
      rvalid   <= '0;
`ifdef ARB_BURST_EN
      holder    <= '0;
      burst_cnt <= '0;
`endif
    end else begin
      // Read return pipe: stage 1 tracks the command on the bus, stage 2 is rvalid.
      p1_vld <= sel_any && !we[sel_id];
      p1_id  <= sel_id;
      rvalid <= p1_vld ? (N_REQ'(1) << p1_id) : '0;

      if (sel_any) begin
        ptr      <= sel_id;
        sram_csn <= 1'b0;
        sram_wen <= we[sel_id];
        sram_ad  <= addr[int'(sel_id)*AW +: AW];
        sram_din <= wdata[int'(sel_id)*DW +: DW];
      end else begin
        sram_csn <= 1'b1;
        sram_wen <= 1'b0;
      end

`ifdef ARB_BURST_EN
      if (!sel_any) begin
        state     <= IDLE;
        burst_cnt <= '0;
      end else if (lock[sel_id]) begin
        state  <= LOCKED;
        holder <= sel_id;
        // Continue the count only for an uninterrupted burst by the same holder;
        // an exhausted holder re-won by rr starts a fresh burst.
        if (state == LOCKED && holder == sel_id && burst_cnt < CW'(MAX_BURST))
          burst_cnt <= burst_cnt + 1'b1;
        else
          burst_cnt <= CW'(1);
      end else begin
        state     <= ISSUE;
        burst_cnt <= '0;
      end
`else
      state <= sel_any ? ISSUE : IDLE;
`endif
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

  localparam int N  = 3;
  localparam int AW = 19;
  localparam int DW = 16;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req, we, lock;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata;
  logic            sram_csn, sram_wen;
  logic [AW-1:0]   sram_ad;
  logic [DW-1:0]   sram_din;
  logic [DW-1:0]   sram_dout;

  int checks = 0;
  int errors = 0;

  sram_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .MAX_BURST(8)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .lock(lock), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .sram_csn(sram_csn), .sram_wen(sram_wen), .sram_ad(sram_ad),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model (low 10 address bits), with a backdoor preload port.
  logic [DW-1:0] mem [0:1023];
  logic          pre_en;
  logic [9:0]    pre_a;
  logic [DW-1:0] pre_d;

  always @(posedge clk) begin
    if (pre_en) mem[pre_a] <= pre_d;
    else if (!sram_csn) begin
      if (sram_wen) mem[sram_ad[9:0]] <= sram_din;
      else          sram_dout <= mem[sram_ad[9:0]];
    end
  end

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [DW-1:0] d);
    pre_en = 1'b1; pre_a = a; pre_d = d;
    next_cyc();
    pre_en = 1'b0;
  endtask

  task automatic clear_inputs;
    req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
  endtask

  task automatic pulse_reset;
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    addr[i*AW +: AW] = a;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      req   = 3'($urandom());
      we    = 3'($urandom());
      lock  = 3'($urandom());
      addr  = 57'({$urandom(), $urandom()});
      wdata = 48'({$urandom(), $urandom()});
      @(negedge clk);
      checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b expected 000", gnt); end
      checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL reset_rvalid: got %b expected 000", rvalid); end
      checks++; if (sram_csn !== 1'b1) begin errors++; $display("FAIL reset_csn: got %b expected 1", sram_csn); end
      checks++; if (sram_wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b expected 0", sram_wen); end
      checks++; if (sram_ad !== 19'h0) begin errors++; $display("FAIL reset_ad: got %h expected 0", sram_ad); end
      checks++; if (sram_din !== 16'h0) begin errors++; $display("FAIL reset_din: got %h expected 0", sram_din); end
      checks++; if (rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
      next_cyc();
    end
    clear_inputs();
    rst = 1'b0;
    next_cyc();
  endtask

  task automatic test_single_read;
    preload(10'h001, 16'hBEEF);
    req = 3'b010; we = 3'b000; set_addr(1, 19'h40001);
    @(negedge clk);
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL rd_gnt: got %b expected 010", gnt); end
    next_cyc();
    req = 3'b000;
    @(negedge clk);
    checks++; if (sram_csn !== 1'b0) begin errors++; $display("FAIL rd_csn: got %b expected 0", sram_csn); end
    checks++; if (sram_wen !== 1'b0) begin errors++; $display("FAIL rd_wen: got %b expected 0", sram_wen); end
    checks++; if (sram_ad !== 19'h40001) begin errors++; $display("FAIL rd_ad: got %h expected 40001", sram_ad); end
    checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL rd_early_rvalid: got %b expected 000", rvalid); end
    next_cyc();
    @(negedge clk);
    checks++; if (rvalid !== 3'b010) begin errors++; $display("FAIL rd_rvalid: got %b expected 010", rvalid); end
    checks++; if (rdata !== 16'hBEEF) begin errors++; $display("FAIL rd_rdata: got %h expected beef", rdata); end
    checks++; if (sram_csn !== 1'b1) begin errors++; $display("FAIL rd_idle_csn: got %b expected 1", sram_csn); end
    next_cyc();
    @(negedge clk);
    checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL rd_one_shot: got %b expected 000", rvalid); end
    next_cyc();
  endtask

  task automatic test_round_robin;
    logic [2:0] eg;
    pulse_reset();
    preload(10'h010, 16'hA000);
    preload(10'h020, 16'hA001);
    preload(10'h030, 16'hA002);
    set_addr(0, 19'h00010); set_addr(1, 19'h00020); set_addr(2, 19'h00030);
    we = 3'b000; req = 3'b111;
    for (int i = 0; i < 8; i++) begin
      if (i == 6) req = 3'b000;
      @(negedge clk);
      if (i < 6) begin
        eg = 3'b001 << (i % 3);
        checks++; if (gnt !== eg) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, gnt, eg); end
      end
      if (i >= 1 && i <= 6) begin
        checks++; if (sram_csn !== 1'b0) begin errors++; $display("FAIL rr_csn[%0d]: got %b expected 0", i, sram_csn); end
        checks++; if (sram_ad !== 19'(16 * ((i - 1) % 3 + 1))) begin errors++; $display("FAIL rr_ad[%0d]: got %h expected %h", i, sram_ad, 19'(16 * ((i - 1) % 3 + 1))); end
      end
      if (i >= 2) begin
        eg = 3'b001 << ((i - 2) % 3);
        checks++; if (rvalid !== eg) begin errors++; $display("FAIL rr_rvalid[%0d]: got %b expected %b", i, rvalid, eg); end
        checks++; if (rdata !== 16'(16'hA000 + (i - 2) % 3)) begin errors++; $display("FAIL rr_rdata[%0d]: got %h expected %h", i, rdata, 16'(16'hA000 + (i - 2) % 3)); end
      end
      next_cyc();
    end
    clear_inputs();
  endtask

  task automatic test_write_then_read;
    req = 3'b001; we = 3'b001; set_addr(0, 19'h00200); wdata[0 +: DW] = 16'h1234;
    @(negedge clk);
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL wr_gnt: got %b expected 001", gnt); end
    next_cyc();
    req = 3'b100; we = 3'b000; set_addr(2, 19'h00200);
    @(negedge clk);
    checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL wr_rd_gnt: got %b expected 100", gnt); end
    checks++; if ({sram_csn, sram_wen} !== 2'b01) begin errors++; $display("FAIL wr_cmd: got %b expected 01", {sram_csn, sram_wen}); end
    checks++; if (sram_din !== 16'h1234) begin errors++; $display("FAIL wr_din: got %h expected 1234", sram_din); end
    next_cyc();
    req = 3'b000;
    @(negedge clk);
    checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL wr_no_rvalid: got %b expected 000", rvalid); end
    checks++; if ({sram_csn, sram_wen} !== 2'b00) begin errors++; $display("FAIL wr_rd_cmd: got %b expected 00", {sram_csn, sram_wen}); end
    next_cyc();
    @(negedge clk);
    checks++; if (rvalid !== 3'b100) begin errors++; $display("FAIL wr_rd_rvalid: got %b expected 100", rvalid); end
    checks++; if (rdata !== 16'h1234) begin errors++; $display("FAIL wr_rd_rdata: got %h expected 1234", rdata); end
    next_cyc();
    clear_inputs();
  endtask

  task automatic test_reset_midop;
    req = 3'b010; we = 3'b000; set_addr(1, 19'h40001);
    @(negedge clk);
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL mid_gnt: got %b expected 010", gnt); end
    next_cyc();
    req = 3'b000;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (sram_csn !== 1'b1) begin errors++; $display("FAIL mid_csn: got %b expected 1", sram_csn); end
    next_cyc();
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL mid_rvalid[%0d]: got %b expected 000", n, rvalid); end
      checks++; if ({sram_csn, sram_wen, sram_ad} !== {2'b10, 19'h0}) begin errors++; $display("FAIL mid_bus[%0d]: got %b %b %h expected 1 0 0", n, sram_csn, sram_wen, sram_ad); end
      next_cyc();
    end
    clear_inputs();
  endtask

  task automatic test_burst;
    logic [2:0] exp_g [$];
`ifdef ARB_BURST_EN
    exp_g = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001,
              3'b010, 3'b100, 3'b001};
`else
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`endif
    pulse_reset();
    req = 3'b111; we = 3'b000; lock = 3'b001;
    for (int i = 0; i < exp_g.size(); i++) begin
      @(negedge clk);
      checks++; if (gnt !== exp_g[i]) begin errors++; $display("FAIL burst_gnt[%0d]: got %b expected %b", i, gnt, exp_g[i]); end
      next_cyc();
    end
    clear_inputs();
    next_cyc();
    next_cyc();
  endtask

  initial begin
    rst = 1'b1;
    pre_en = 1'b0; pre_a = '0; pre_d = '0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_then_read();
    test_reset_midop();
    test_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
